// File: rtl/beep_pkg.sv
// Shared types, constants and helpers for the beeper scheduler.
// Pure declarations: no latency, no flow control.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] beeps;
    logic [7:0] on;
    logic [7:0] off;
  } pattern_t;

  localparam pattern_t CLICK   = '{beeps: 3'd1, on: 8'd30,  off: 8'd20};
  localparam pattern_t ALARM   = '{beeps: 3'd3, on: 8'd200, off: 8'd100};
  localparam pattern_t CONFIRM = '{beeps: 3'd2, on: 8'd80,  off: 8'd80};

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beep_scheduler_if.sv
// Requester-side bundle of the beeper scheduler: request pulses, patterns, controls, beeper status.
// Wires only; a request is a one-cycle pulse with no ready, so a repeat simply overwrites.
interface beep_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TW      = 8,
  parameter int IW      = beep_pkg::id_w(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*3-1:0]  req_beeps;
  logic [NUM_REQ*TW-1:0] req_on;
  logic [NUM_REQ*TW-1:0] req_off;
  logic                  mute;
  logic                  abort;
  logic                  beep;
  logic                  busy;
  logic [IW-1:0]         grant_id;
  logic                  done;

  modport master (
    output req, req_beeps, req_on, req_off, mute, abort,
    input  beep, busy, grant_id, done
  );

  modport slave (
    input  req, req_beeps, req_on, req_off, mute, abort,
    output beep, busy, grant_id, done
  );
endinterface

// File: rtl/beep_scheduler_prio_pick.sv
// Combinational lowest-index-first picker over a request vector.
// Zero latency; no flow control.
module prio_pick import beep_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic          vld,
  output logic [IW-1:0] idx
);
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        vld = 1'b1;
        idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/beep_scheduler.sv
// Latches one-cycle beep requests and plays their patterns one at a time, lowest index first.
// Grant one cycle after a request is seen in IDLE; requests never stall, a repeat overwrites its shadow.
module beep_scheduler import beep_pkg::*; #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 1,
  parameter int TW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  beep_scheduler_if.slave bus
);
  localparam int IW = id_w(NUM_REQ);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    pend_q, pend_d;
  logic [NUM_REQ*3-1:0]  sh_beeps_q, sh_beeps_d;
  logic [NUM_REQ*TW-1:0] sh_on_q, sh_on_d;
  logic [NUM_REQ*TW-1:0] sh_off_q, sh_off_d;
  logic [2:0]            beeps_q, beeps_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         on_q, on_d;
  logic [TW-1:0]         off_q, off_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic                  done_q, done_d;

  logic                  pick_vld;
  logic [IW-1:0]         pick_idx;
  logic                  tick;
  logic [2:0]            sel_b, norm_b;
  logic [TW-1:0]         sel_on, sel_off, norm_on, norm_off;

  prio_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .vec (pend_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign tick    = (presc_q == PRESC_MAX);
  assign sel_b   = sh_beeps_q[int'(pick_idx) * 3 +: 3];
  assign sel_on  = sh_on_q[int'(pick_idx) * TW +: TW];
  assign sel_off = sh_off_q[int'(pick_idx) * TW +: TW];
  // Zero fields mean "minimum pattern" so counters can never wrap.
  assign norm_b   = (sel_b == 3'd0)    ? 3'd1    : sel_b;
  assign norm_on  = (sel_on == '0)     ? TW'(1)  : sel_on;
  assign norm_off = (sel_off == '0)    ? TW'(1)  : sel_off;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    sh_beeps_d = sh_beeps_q;
    sh_on_d    = sh_on_q;
    sh_off_d   = sh_off_q;
    beeps_d    = beeps_q;
    cnt_d      = cnt_q;
    on_d       = on_q;
    off_d      = off_q;
    gid_d      = gid_q;
    done_d     = 1'b0;
    presc_d    = tick ? '0 : presc_q + 1'b1;

    if (bus.abort) begin
      state_d = ST_IDLE;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            pend_d[pick_idx] = 1'b0;
            beeps_d = norm_b;
            on_d    = norm_on;
            off_d   = norm_off;
            cnt_d   = norm_on;
            gid_d   = pick_idx;
            presc_d = '0;
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (tick) begin
            if (cnt_q == TW'(1)) begin
              cnt_d   = off_q;
              state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (cnt_q == TW'(1)) begin
              if (beeps_q > 3'd1) begin
                beeps_d = beeps_q - 1'b1;
                cnt_d   = on_q;
                state_d = ST_ON;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // New requests land after the grant clear so a same-cycle repeat is not lost.
      pend_d = pend_d | bus.req;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i]) begin
          sh_beeps_d[i*3 +: 3]  = bus.req_beeps[i*3 +: 3];
          sh_on_d[i*TW +: TW]   = bus.req_on[i*TW +: TW];
          sh_off_d[i*TW +: TW]  = bus.req_off[i*TW +: TW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      sh_beeps_q <= '0;
      sh_on_q    <= '0;
      sh_off_q   <= '0;
      beeps_q    <= '0;
      cnt_q      <= '0;
      on_q       <= '0;
      off_q      <= '0;
      presc_q    <= '0;
      gid_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sh_beeps_q <= sh_beeps_d;
      sh_on_q    <= sh_on_d;
      sh_off_q   <= sh_off_d;
      beeps_q    <= beeps_d;
      cnt_q      <= cnt_d;
      on_q       <= on_d;
      off_q      <= off_d;
      presc_q    <= presc_d;
      gid_q      <= gid_d;
      done_q     <= done_d;
    end
  end

  assign bus.beep     = (state_q == ST_ON) && !bus.mute;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.grant_id = gid_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_beep_scheduler.sv
// Bench for beep_scheduler: two instances (TICK_DIV 1 and 5) against a pattern-level model.
module tb_beep_scheduler;
  import beep_pkg::*;

  localparam int NR = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_s, mute_s, abort_s;
  logic [NR-1:0]    req_s   [2];
  logic [NR*3-1:0]  bts_s   [2];
  logic [NR*TW-1:0] on_s    [2];
  logic [NR*TW-1:0] off_s   [2];
  logic [1:0]       o_beep, o_busy, o_done;
  logic [1:0]       o_gid   [2];

  int checks = 0;
  int errors = 0;

  beep_scheduler_if #(.NUM_REQ(NR), .TW(TW)) bus1 ();
  beep_scheduler_if #(.NUM_REQ(NR), .TW(TW)) bus5 ();

  assign bus1.req       = req_s[0];
  assign bus1.req_beeps = bts_s[0];
  assign bus1.req_on    = on_s[0];
  assign bus1.req_off   = off_s[0];
  assign bus1.mute      = mute_s[0];
  assign bus1.abort     = abort_s[0];
  assign o_beep[0]      = bus1.beep;
  assign o_busy[0]      = bus1.busy;
  assign o_done[0]      = bus1.done;
  assign o_gid[0]       = bus1.grant_id;

  assign bus5.req       = req_s[1];
  assign bus5.req_beeps = bts_s[1];
  assign bus5.req_on    = on_s[1];
  assign bus5.req_off   = off_s[1];
  assign bus5.mute      = mute_s[1];
  assign bus5.abort     = abort_s[1];
  assign o_beep[1]      = bus5.beep;
  assign o_busy[1]      = bus5.busy;
  assign o_done[1]      = bus5.done;
  assign o_gid[1]       = bus5.grant_id;

  beep_scheduler #(.NUM_REQ(NR), .TICK_DIV(1), .TW(TW)) dut1 (
    .clk (clk), .rst (rst_s[0]), .bus (bus1.slave)
  );
  beep_scheduler #(.NUM_REQ(NR), .TICK_DIV(5), .TW(TW)) dut5 (
    .clk (clk), .rst (rst_s[1]), .bus (bus5.slave)
  );

  // Pattern-level model: a playing pattern is a cycle offset k into N*(on+off)*div cycles.
  logic [NR-1:0] m_pend [2];
  int m_shb [2][NR];
  int m_shon [2][NR];
  int m_shoff [2][NR];
  bit m_play [2];
  bit m_done [2];
  int m_k [2];
  int m_n [2];
  int m_on [2];
  int m_off [2];
  int m_gid [2];

  task automatic chk(input string nm, input int u, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s unit=%0d t=%0t got=%0d want=%0d", nm, u, $time, act, want);
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int td;
      int lo;
      bit dn;
      td = (u == 0) ? 1 : 5;
      if (rst_s[u]) begin
        m_pend[u] = '0;
        m_play[u] = 1'b0;
        m_done[u] = 1'b0;
        m_gid[u]  = 0;
        m_k[u]    = 0;
      end else if (abort_s[u]) begin
        m_pend[u] = '0;
        m_play[u] = 1'b0;
        m_done[u] = 1'b0;
      end else begin
        dn = 1'b0;
        if (m_play[u]) begin
          m_k[u]++;
          if (m_k[u] == m_n[u] * (m_on[u] + m_off[u]) * td) begin
            m_play[u] = 1'b0;
            dn = 1'b1;
          end
        end else if (m_pend[u] != '0) begin
          lo = 0;
          for (int i = NR - 1; i >= 0; i--) if (m_pend[u][i]) lo = i;
          m_pend[u][lo] = 1'b0;
          m_n[u]   = (m_shb[u][lo] == 0) ? 1 : m_shb[u][lo];
          m_on[u]  = (m_shon[u][lo] == 0) ? 1 : m_shon[u][lo];
          m_off[u] = (m_shoff[u][lo] == 0) ? 1 : m_shoff[u][lo];
          m_k[u]   = 0;
          m_play[u] = 1'b1;
          m_gid[u] = lo;
        end
        for (int i = 0; i < NR; i++) begin
          if (req_s[u][i]) begin
            m_pend[u][i]  = 1'b1;
            m_shb[u][i]   = int'(bts_s[u][3*i +: 3]);
            m_shon[u][i]  = int'(on_s[u][TW*i +: TW]);
            m_shoff[u][i] = int'(off_s[u][TW*i +: TW]);
          end
        end
        m_done[u] = dn;
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int td;
      int ph;
      bit eb;
      td = (u == 0) ? 1 : 5;
      eb = 1'b0;
      if (!rst_s[u] && m_play[u]) begin
        ph = (m_k[u] / td) % (m_on[u] + m_off[u]);
        eb = (ph < m_on[u]) && !mute_s[u];
      end
      chk("beep", u, int'(o_beep[u]), int'(eb));
      chk("busy", u, int'(o_busy[u]), int'(!rst_s[u] && m_play[u]));
      chk("done", u, int'(o_done[u]), int'(!rst_s[u] && m_done[u]));
      chk("grant_id", u, int'(o_gid[u]), rst_s[u] ? 0 : m_gid[u]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pat(input int u, input int i, input int b, input int on, input int off);
    bts_s[u][3*i +: 3]  = 3'(b);
    on_s[u][TW*i +: TW]  = TW'(on);
    off_s[u][TW*i +: TW] = TW'(off);
  endtask

  // Request sampled on the second edge; returns just after it, so grant is the next edge.
  task automatic pulse(input int u, input logic [NR-1:0] m);
    cyc(1);
    req_s[u] = m;
    cyc(1);
    req_s[u] = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    int nb;
    int nbusy;

    rst_s   = 2'b11;
    mute_s  = 2'b00;
    abort_s = 2'b00;
    for (int u = 0; u < 2; u++) begin
      req_s[u] = '0;
      bts_s[u] = '0;
      on_s[u]  = '0;
      off_s[u] = '0;
    end
    cyc(3);
    rst_s = 2'b00;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_beep", u, int'(o_beep[u]), 0);
      chk("rst_busy", u, int'(o_busy[u]), 0);
      chk("rst_done", u, int'(o_done[u]), 0);
      chk("rst_gid", u, int'(o_gid[u]), 0);
    end

    // Single request: 2 beeps, 3 on, 2 off.
    set_pat(0, 2, 2, 3, 2);
    pulse(0, 4'b0100);
    cyc(1);
    pat = 10'b1110011100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t1_beep", 0, int'(o_beep[0]), int'(pat[9-c]));
      chk("t1_busy", 0, int'(o_busy[0]), 1);
    end
    @(negedge clk);
    chk("t1_done", 0, int'(o_done[0]), 1);
    chk("t1_busy_end", 0, int'(o_busy[0]), 0);
    chk("t1_gid", 0, int'(o_gid[0]), 2);
    @(negedge clk);
    chk("t1_done_once", 0, int'(o_done[0]), 0);

    // Simultaneous requests 3 and 1.
    set_pat(0, 1, 1, 4, 4);
    set_pat(0, 3, 1, 4, 4);
    pulse(0, 4'b1010);
    cyc(1);
    @(negedge clk);
    chk("t2_gid_first", 0, int'(o_gid[0]), 1);
    repeat (8) @(negedge clk);
    chk("t2_done_first", 0, int'(o_done[0]), 1);
    @(negedge clk);
    chk("t2_gid_second", 0, int'(o_gid[0]), 3);
    chk("t2_beep_second", 0, int'(o_beep[0]), 1);
    cyc(9);

    // Zero fields, then no preemption of an active pattern.
    set_pat(0, 0, 0, 0, 0);
    pulse(0, 4'b0001);
    cyc(1);
    @(negedge clk);
    chk("t3_zero_on", 0, int'(o_beep[0]), 1);
    @(negedge clk);
    chk("t3_zero_off_beep", 0, int'(o_beep[0]), 0);
    chk("t3_zero_off_busy", 0, int'(o_busy[0]), 1);
    @(negedge clk);
    chk("t3_zero_done", 0, int'(o_done[0]), 1);
    set_pat(0, 2, 1, 5, 3);
    pulse(0, 4'b0100);
    cyc(2);
    set_pat(0, 0, 1, 1, 1);
    pulse(0, 4'b0001);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t3_nopreempt_gid", 0, int'(o_gid[0]), 2);
    chk("t3_nopreempt_busy", 0, int'(o_busy[0]), 1);
    @(negedge clk);
    chk("t3_req2_done", 0, int'(o_done[0]), 1);
    @(negedge clk);
    chk("t3_req0_gid", 0, int'(o_gid[0]), 0);
    chk("t3_req0_beep", 0, int'(o_beep[0]), 1);
    cyc(4);

    // Mute: 3 beeps, 2 on, 2 off.
    set_pat(0, 1, 3, 2, 2);
    mute_s[0] = 1'b1;
    pulse(0, 4'b0010);
    cyc(1);
    nb = 0;
    nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nb += int'(o_beep[0]);
      nbusy += int'(o_busy[0]);
    end
    @(negedge clk);
    chk("t4_mute_done", 0, int'(o_done[0]), 1);
    chk("t4_mute_beeps", 0, nb, 0);
    chk("t4_mute_busy_cycles", 0, nbusy, 12);
    cyc(1);
    mute_s[0] = 1'b0;

    // Abort in the second ON phase with a pending request and a coincident request.
    pulse(0, 4'b0010);
    cyc(1);
    set_pat(0, 2, 1, 1, 1);
    req_s[0] = 4'b0100;
    cyc(1);
    req_s[0] = '0;
    cyc(3);
    abort_s[0] = 1'b1;
    req_s[0] = 4'b1000;
    @(negedge clk);
    chk("t4_on2_beep", 0, int'(o_beep[0]), 1);
    cyc(1);
    abort_s[0] = 1'b0;
    req_s[0] = '0;
    @(negedge clk);
    chk("t4_abort_beep", 0, int'(o_beep[0]), 0);
    chk("t4_abort_busy", 0, int'(o_busy[0]), 0);
    chk("t4_abort_done", 0, int'(o_done[0]), 0);
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nbusy += int'(o_busy[0]);
    end
    chk("t4_abort_flushed", 0, nbusy, 0);

    // Prescaler: TICK_DIV=5, 1 beep, 2 on, 1 off.
    set_pat(1, 0, 1, 2, 1);
    pulse(1, 4'b0001);
    cyc(1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("t5_beep", 1, int'(o_beep[1]), (c < 10) ? 1 : 0);
    end
    @(negedge clk);
    chk("t5_done", 1, int'(o_done[1]), 1);
    chk("t5_busy_end", 1, int'(o_busy[1]), 0);

    // Reset in the middle of an ON phase with a request pending.
    set_pat(1, 1, 1, 1, 1);
    pulse(1, 4'b0001);
    cyc(1);
    req_s[1] = 4'b0010;
    cyc(1);
    req_s[1] = '0;
    cyc(2);
    @(negedge clk);
    chk("t5_pre_rst_beep", 1, int'(o_beep[1]), 1);
    #2;
    rst_s[1] = 1'b1;
    #1;
    chk("t5_rst_beep", 1, int'(o_beep[1]), 0);
    chk("t5_rst_busy", 1, int'(o_busy[1]), 0);
    chk("t5_rst_done", 1, int'(o_done[1]), 0);
    cyc(2);
    rst_s[1] = 1'b0;
    nbusy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nbusy += int'(o_busy[1]);
    end
    chk("t5_rst_no_pending", 1, nbusy, 0);
    chk("t5_rst_gid", 1, int'(o_gid[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
